// File: rtl/alu_mpseq_pkg.sv
// Shared definitions for the multi-precision ALU sequencer: command codes,
// ALU op encodings, FSM state encoding and the completion flag bundle.
// Ports: none (package).
package alu_mpseq_pkg;

    // Command opcodes as presented on cmd_op
    typedef enum logic [1:0] {
        CMD_ADD = 2'b00,
        CMD_SUB = 2'b01,
        CMD_CMP = 2'b10,
        CMD_AND = 2'b11
    } cmd_op_e;

    // ALU op encodings driven on alu_op
    localparam logic [3:0] ALU_OP_ADD = 4'b0011;  // AI + BI + CI
    localparam logic [3:0] ALU_OP_SUB = 4'b0111;  // AI + ~BI + CI
    localparam logic [3:0] ALU_OP_AND = 4'b1101;  // AI & BI, CO forced 0

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } flags_t;

    // SUB and CMP share the subtract encoding; CMP differs only in carry-in
    // and in suppressing the result stream.
    function automatic logic [3:0] alu_op_of(input cmd_op_e op);
        case (op)
            CMD_ADD: return ALU_OP_ADD;
            CMD_AND: return ALU_OP_AND;
            default: return ALU_OP_SUB;
        endcase
    endfunction

endpackage

// File: rtl/alu_mpseq_if.sv
// Bus bundles for the sequencer.
// alu_mpseq_if: command / operand / result / completion streams between a
//   requester (master) and the sequencer (slave).
// alu_mpseq_alu_if: control and data lines between the sequencer (master)
//   and the shared ALU (slave).
interface alu_mpseq_if #(
    parameter int DW    = 16,
    parameter int LEN_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_ci;
    logic             opd_valid;
    logic             opd_ready;
    logic [DW-1:0]    opd_a;
    logic [DW-1:0]    opd_b;
    logic             res_valid;
    logic             res_ready;
    logic [DW-1:0]    res_data;
    logic             done_valid;
    logic             done_c;
    logic             done_z;
    logic             done_n;
    logic             done_v;
    logic             busy;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_ci,
        output opd_valid, opd_a, opd_b, res_ready,
        input  cmd_ready, opd_ready, res_valid, res_data,
        input  done_valid, done_c, done_z, done_n, done_v, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_ci,
        input  opd_valid, opd_a, opd_b, res_ready,
        output cmd_ready, opd_ready, res_valid, res_data,
        output done_valid, done_c, done_z, done_n, done_v, busy
    );
endinterface

interface alu_mpseq_alu_if #(
    parameter int DW    = 16,
    parameter int LOGDW = 4
);
    logic [3:0]       alu_op;
    logic [DW-1:0]    alu_ai;
    logic [DW-1:0]    alu_bi;
    logic             alu_ci;
    logic             alu_rdy;
    logic             alu_right;
    logic             alu_rotate;
    logic             alu_multiply;
    logic [LOGDW-1:0] alu_di;
    logic [DW-1:0]    alu_out;
    logic             alu_co;
    logic             alu_z;
    logic             alu_n;
    logic             alu_v;

    modport master (
        output alu_op, alu_ai, alu_bi, alu_ci, alu_rdy,
        output alu_right, alu_rotate, alu_multiply, alu_di,
        input  alu_out, alu_co, alu_z, alu_n, alu_v
    );

    modport slave (
        input  alu_op, alu_ai, alu_bi, alu_ci, alu_rdy,
        input  alu_right, alu_rotate, alu_multiply, alu_di,
        output alu_out, alu_co, alu_z, alu_n, alu_v
    );
endinterface

// File: rtl/alu.sv
// Shared ALU: registered add / subtract / logic unit, outputs update on RDY.
// Latency: one cycle from RDY to OUT/flags; holds result while RDY is low.
// Backpressure: none of its own; RDY is the only enable.
// Ports: clk; op/right/rotate/multiply/di/BCD control; AI/BI/CI operands;
//        RDY clock enable; OUT/CO/V/Z/N registered result and flags.
module ALU #(
    parameter int dw    = 16,
    parameter int logdw = 4
) (
    input  logic             clk,
    input  logic [3:0]       op,
    input  logic             right,
    input  logic             rotate,
    input  logic             multiply,
    input  logic [logdw-1:0] di,
    input  logic [dw-1:0]    AI,
    input  logic [dw-1:0]    BI,
    input  logic             CI,
    input  logic             BCD,
    input  logic             RDY,
    output logic [dw-1:0]    OUT,
    output logic             CO,
    output logic             V,
    output logic             Z,
    output logic             N
);
    logic [dw:0]   sum;
    logic [dw-1:0] bx;
    logic [dw-1:0] res;
    logic          co_w;
    logic          v_w;
    logic          unused_ctl;

    // Multiply, distance shifts and decimal mode are not exercised here.
    assign unused_ctl = ^{multiply, di, BCD};

    always_comb begin
        bx   = (op == 4'b0111) ? ~BI : BI;
        sum  = {1'b0, AI} + {1'b0, bx} + {{dw{1'b0}}, CI};
        res  = AI;
        co_w = 1'b0;
        v_w  = 1'b0;
        case (op)
            4'b0011, 4'b0111: begin
                res  = sum[dw-1:0];
                co_w = sum[dw];
                v_w  = (AI[dw-1] == bx[dw-1]) && (sum[dw-1] != AI[dw-1]);
            end
            4'b1101: res = AI & BI;
            default: begin
                if (right) begin
                    res  = {rotate ? CI : 1'b0, AI[dw-1:1]};
                    co_w = AI[0];
                end
            end
        endcase
    end

    // Deliberately not reset: the sequencer never reads these before an issue.
    always_ff @(posedge clk) begin
        if (RDY) begin
            OUT <= res;
            CO  <= co_w;
            V   <= v_w;
            Z   <= (res == '0);
            N   <= res[dw-1];
        end
    end
endmodule

// File: rtl/alu_mpseq.sv
// Multi-precision sequencer: streams LSW-first word pairs through the ALU,
//   chaining carry, and reports accumulated C/Z/N/V on a one-cycle done pulse.
// Latency: word k issues in cycle k+1, result valid k+2, done at len+3.
// Backpressure: a res_ready stall blocks further issue (one word in flight, no skid).
// Ports: clk, reset_n (async active-low); bus = command/operand/result/done
//        streams (slave side); alu = shared ALU control/data (master side).
module alu_mpseq
    import alu_mpseq_pkg::*;
#(
    parameter int DW    = 16,
    parameter int LOGDW = 4,
    parameter int LEN_W = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    alu_mpseq_if.slave      bus,
    alu_mpseq_alu_if.master alu
);
    state_e           state_q, state_d;
    cmd_op_e          op_q;
    logic [LEN_W-1:0] len_q;
    logic             ci_q;
    logic [LEN_W:0]   issued_q;
    logic             inflight_q;
    logic             z_acc_q;
    flags_t           done_q;
    logic             armed_q;

    logic             in_run;
    logic             is_cmp;
    logic             cmd_rdy;
    logic             accept;
    logic             opd_rdy;
    logic             issue;
    logic             consume;
    logic             last_consume;
    logic [LEN_W:0]   last_cnt;
    logic [3:0]       alu_op_w;
    logic             alu_ci_w;
    logic [DW-1:0]    res_data_w;

    assign in_run   = (state_q == ST_RUN);
    assign is_cmp   = (op_q == CMD_CMP);
    // Issue count after the final word has gone out
    assign last_cnt = {1'b0, len_q} + {{LEN_W{1'b0}}, 1'b1};
    assign accept   = bus.cmd_valid && cmd_rdy;
    assign issue    = bus.opd_valid && opd_rdy;
    // CMP results are swallowed one cycle after issue
    assign consume      = inflight_q && (is_cmp || bus.res_ready);
    assign last_consume = consume && (issued_q == last_cnt);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (last_consume) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        // armed_q keeps cmd_ready low while reset is asserted
        cmd_rdy  = (state_q == ST_IDLE) && armed_q;
        opd_rdy  = in_run && (issued_q <= {1'b0, len_q})
                   && (!inflight_q || bus.res_ready || is_cmp);
        alu_op_w = in_run ? alu_op_of(op_q) : 4'b0000;
        alu_ci_w = 1'b0;
        if (in_run && (op_q != CMD_AND)) begin
            if (issued_q == '0) alu_ci_w = is_cmp ? 1'b1 : ci_q;
            // ALU holds CO of the previous word because RDY was low since
            else                alu_ci_w = alu.alu_co;
        end
        res_data_w = alu.alu_out;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_q    <= 1'b0;
            op_q       <= CMD_ADD;
            len_q      <= '0;
            ci_q       <= 1'b0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            z_acc_q    <= 1'b0;
            done_q     <= '0;
        end else begin
            armed_q <= 1'b1;
            if (accept) begin
                op_q       <= cmd_op_e'(bus.cmd_op);
                len_q      <= bus.cmd_len;
                ci_q       <= bus.cmd_ci;
                issued_q   <= '0;
                inflight_q <= 1'b0;
                z_acc_q    <= 1'b1;
            end else begin
                if (issue) issued_q <= issued_q + {{LEN_W{1'b0}}, 1'b1};
                if (issue)        inflight_q <= 1'b1;
                else if (consume) inflight_q <= 1'b0;
                if (consume) z_acc_q <= z_acc_q & alu.alu_z;
                if (last_consume) begin
                    done_q.c <= alu.alu_co;
                    done_q.z <= z_acc_q & alu.alu_z;
                    done_q.n <= alu.alu_n;
                    done_q.v <= alu.alu_v;
                end
            end
        end
    end

    assign bus.cmd_ready  = cmd_rdy;
    assign bus.opd_ready  = opd_rdy;
    assign bus.res_valid  = inflight_q && !is_cmp;
    assign bus.res_data   = res_data_w;
    assign bus.done_valid = (state_q == ST_DONE);
    assign bus.done_c     = done_q.c;
    assign bus.done_z     = done_q.z;
    assign bus.done_n     = done_q.n;
    assign bus.done_v     = done_q.v;
    assign bus.busy       = (state_q != ST_IDLE);

    assign alu.alu_op       = alu_op_w;
    assign alu.alu_ai       = bus.opd_a;
    assign alu.alu_bi       = bus.opd_b;
    assign alu.alu_ci       = alu_ci_w;
    assign alu.alu_rdy      = issue;
    assign alu.alu_right    = 1'b0;
    assign alu.alu_rotate   = 1'b0;
    assign alu.alu_multiply = 1'b0;
    assign alu.alu_di       = {LOGDW{1'b0}};
endmodule

// File: tb/tb_alu_mpseq.sv
// Directed-vector bench for alu_mpseq driving the shared ALU.
// Latency: checks issue/done cycle positions against hand-computed values.
// Backpressure: exercises a res_ready stall and reset in the middle of a run.
module tb_alu_mpseq;
    import alu_mpseq_pkg::*;

    localparam int DW    = 16;
    localparam int LOGDW = 4;
    localparam int LEN_W = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    alu_mpseq_if     #(.DW(DW), .LEN_W(LEN_W)) bus ();
    alu_mpseq_alu_if #(.DW(DW), .LOGDW(LOGDW)) abus ();

    alu_mpseq #(.DW(DW), .LOGDW(LOGDW), .LEN_W(LEN_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .alu     (abus.master)
    );

    ALU #(.dw(DW), .logdw(LOGDW)) u_alu (
        .clk      (clk),
        .op       (abus.alu_op),
        .right    (abus.alu_right),
        .rotate   (abus.alu_rotate),
        .multiply (abus.alu_multiply),
        .di       (abus.alu_di),
        .AI       (abus.alu_ai),
        .BI       (abus.alu_bi),
        .CI       (abus.alu_ci),
        .BCD      (1'b0),
        .RDY      (abus.alu_rdy),
        .OUT      (abus.alu_out),
        .CO       (abus.alu_co),
        .V        (abus.alu_v),
        .Z        (abus.alu_z),
        .N        (abus.alu_n)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] va [16];
    logic [15:0] vb [16];
    logic [15:0] got [16];
    int          n_got;
    int          done_cyc;
    logic [3:0]  got_flags;   // {c, z, n, v}
    int          stall_viol;
    int          ci_viol;
    int          res_seen;
    bit          timed_out;

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_len   = '0;
        bus.cmd_ci    = 1'b0;
        bus.opd_valid = 1'b0;
        bus.opd_a     = '0;
        bus.opd_b     = '0;
        bus.res_ready = 1'b1;
    endtask

    // Drives one command and its operand stream; records observations only.
    task automatic run_cmd(input cmd_op_e op, input int len, input logic ci,
                           input int stall_word, input int stall_n);
        int          c;
        int          widx;
        int          scnt;
        bit          stall;
        bit          seen_done;
        logic [15:0] held;
        n_got = 0; done_cyc = -1; stall_viol = 0; ci_viol = 0; res_seen = 0;
        timed_out = 0; widx = 0; scnt = 0; seen_done = 0; held = '0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = LEN_W'(len);
        bus.cmd_ci    = ci;
        #1;
        c = 0;
        while (bus.cmd_ready !== 1'b1 && c < 20) begin
            @(negedge clk); #1; c++;
        end
        if (c >= 20) begin
            timed_out = 1;
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);              // edge 0: command accepted
        #1 bus.cmd_valid = 1'b0;
        c = 1;
        while (!seen_done && c < 64) begin
            @(negedge clk);
            bus.opd_valid = (widx <= len);
            bus.opd_a     = (widx <= len) ? va[widx] : 16'h0000;
            bus.opd_b     = (widx <= len) ? vb[widx] : 16'h0000;
            stall = (bus.res_valid === 1'b1) && (n_got == stall_word) && (scnt < stall_n);
            bus.res_ready = !stall;
            if (stall) begin
                if (scnt == 0) held = bus.res_data;
                scnt++;
            end
            #1;
            if (stall && (abus.alu_rdy !== 1'b0 || bus.opd_ready !== 1'b0 ||
                          bus.res_data !== held)) stall_viol++;
            if (abus.alu_rdy === 1'b1 && op == CMD_AND && abus.alu_ci !== 1'b0) ci_viol++;
            if (bus.res_valid === 1'b1 && op == CMD_CMP) res_seen++;
            if (bus.res_valid === 1'b1 && bus.res_ready && n_got < 16) begin
                got[n_got] = bus.res_data;
                n_got++;
            end
            if (bus.opd_valid && bus.opd_ready === 1'b1) widx++;
            if (bus.done_valid === 1'b1) begin
                done_cyc  = c;
                seen_done = 1;
                got_flags = {bus.done_c, bus.done_z, bus.done_n, bus.done_v};
            end
            c++;
        end
        if (!seen_done) timed_out = 1;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        #2;
        n_tests++;
        if ({bus.busy, bus.cmd_ready, bus.done_valid, abus.alu_rdy, bus.opd_ready, bus.res_valid} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {bus.busy, bus.cmd_ready, bus.done_valid, abus.alu_rdy, bus.opd_ready, bus.res_valid});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b expected 1 0", bus.cmd_ready, bus.busy);
        end
    endtask

    task automatic test_add();
        va[0] = 16'hFFFF; vb[0] = 16'h0001;
        va[1] = 16'h0001; vb[1] = 16'h0000;
        run_cmd(CMD_ADD, 1, 1'b0, -1, 0);
        n_tests++;
        if (timed_out || n_got != 2) begin
            n_fail++; $display("FAIL add_count: got %0d results timeout=%0d expected 2", n_got, timed_out);
        end
        n_tests++;
        if (got[0] !== 16'h0000 || got[1] !== 16'h0002) begin
            n_fail++; $display("FAIL add_res: got %h %h expected 0000 0002", got[0], got[1]);
        end
        n_tests++;
        if (got_flags[3:1] !== 3'b000) begin
            n_fail++; $display("FAIL add_flags_czn: got %b expected 000", got_flags[3:1]);
        end
        n_tests++;
        if (done_cyc != 4) begin
            n_fail++; $display("FAIL add_done_cycle: got %0d expected 4", done_cyc);
        end
    endtask

    task automatic test_sub();
        va[0] = 16'h0000; vb[0] = 16'h0001;
        va[1] = 16'h0000; vb[1] = 16'h0000;
        run_cmd(CMD_SUB, 1, 1'b1, -1, 0);
        n_tests++;
        if (timed_out || n_got != 2 || got[0] !== 16'hFFFF || got[1] !== 16'hFFFF) begin
            n_fail++; $display("FAIL sub_res: got n=%0d %h %h expected 2 ffff ffff", n_got, got[0], got[1]);
        end
        n_tests++;
        if (got_flags !== 4'b0010) begin
            n_fail++; $display("FAIL sub_flags_czn_v: got %b expected 0010", got_flags);
        end
    endtask

    task automatic test_cmp();
        for (int i = 0; i < 3; i++) begin
            va[i] = 16'h1234; vb[i] = 16'h1234;
        end
        run_cmd(CMD_CMP, 2, 1'b0, -1, 0);
        n_tests++;
        if (res_seen != 0 || n_got != 0) begin
            n_fail++; $display("FAIL cmp_no_res: got res_valid cycles %0d expected 0", res_seen);
        end
        n_tests++;
        if (got_flags[3:2] !== 2'b11) begin
            n_fail++; $display("FAIL cmp_flags_cz: got %b expected 11", got_flags[3:2]);
        end
        n_tests++;
        if (timed_out || done_cyc != 5) begin
            n_fail++; $display("FAIL cmp_done_cycle: got %0d expected 5", done_cyc);
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = CMD_ADD; bus.cmd_len = 4'd3; bus.cmd_ci = 1'b0;
        @(posedge clk);                              // edge 0
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);                              // cycle 1: word 0
        bus.opd_valid = 1'b1; bus.opd_a = 16'h1111; bus.opd_b = 16'h2222; bus.res_ready = 1'b1;
        #1;
        n_tests++;
        if (abus.alu_rdy !== 1'b1) begin
            n_fail++; $display("FAIL midop_issue: alu_rdy got %b expected 1", abus.alu_rdy);
        end
        @(negedge clk);                              // cycle 2: reset
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.busy, bus.cmd_ready, bus.opd_ready, bus.res_valid, bus.done_valid,
             abus.alu_rdy, abus.alu_op, abus.alu_ci} !== 11'b0) begin
            n_fail++;
            $display("FAIL midop_reset_ctl: got %b expected 0",
                     {bus.busy, bus.cmd_ready, bus.opd_ready, bus.res_valid, bus.done_valid,
                      abus.alu_rdy, abus.alu_op, abus.alu_ci});
        end
        n_tests++;
        if ({bus.done_c, bus.done_z, bus.done_n, bus.done_v} !== 4'b0000) begin
            n_fail++; $display("FAIL midop_reset_flags: got %b expected 0000",
                               {bus.done_c, bus.done_z, bus.done_n, bus.done_v});
        end
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL midop_cmd_ready: got %b expected 1", bus.cmd_ready);
        end
        va[0] = 16'hFFFF; vb[0] = 16'h0001;
        run_cmd(CMD_ADD, 0, 1'b0, -1, 0);
        n_tests++;
        if (timed_out || n_got != 1 || got[0] !== 16'h0000) begin
            n_fail++; $display("FAIL midop_add_res: got n=%0d %h expected 1 0000", n_got, got[0]);
        end
        n_tests++;
        if ({got_flags[3], got_flags[2], got_flags[0]} !== 3'b110) begin
            n_fail++; $display("FAIL midop_add_flags_czv: got %b expected 110",
                               {got_flags[3], got_flags[2], got_flags[0]});
        end
        n_tests++;
        if (done_cyc != 3) begin
            n_fail++; $display("FAIL midop_done_cycle: got %0d expected 3", done_cyc);
        end
    endtask

    task automatic test_stall();
        va[0] = 16'hFFFF; vb[0] = 16'h0001;
        va[1] = 16'h8000; vb[1] = 16'h8000;
        va[2] = 16'h7FFF; vb[2] = 16'h0000;
        va[3] = 16'h0001; vb[3] = 16'h0002;
        run_cmd(CMD_ADD, 3, 1'b0, -1, 0);
        n_tests++;
        if (timed_out || done_cyc != 6) begin
            n_fail++; $display("FAIL nostall_done_cycle: got %0d expected 6", done_cyc);
        end
        run_cmd(CMD_ADD, 3, 1'b0, 1, 3);
        n_tests++;
        if (n_got != 4 || got[0] !== 16'h0000 || got[1] !== 16'h0001 ||
            got[2] !== 16'h8000 || got[3] !== 16'h0003) begin
            n_fail++; $display("FAIL stall_res: got n=%0d %h %h %h %h expected 4 0000 0001 8000 0003",
                               n_got, got[0], got[1], got[2], got[3]);
        end
        n_tests++;
        if (got_flags !== 4'b0000) begin
            n_fail++; $display("FAIL stall_flags: got %b expected 0000", got_flags);
        end
        n_tests++;
        if (stall_viol != 0) begin
            n_fail++; $display("FAIL stall_hold: got %0d bad stall cycles expected 0", stall_viol);
        end
        n_tests++;
        if (timed_out || done_cyc != 9) begin
            n_fail++; $display("FAIL stall_done_cycle: got %0d expected 9", done_cyc);
        end
    endtask

    task automatic test_and();
        va[0] = 16'h00FF; vb[0] = 16'hFF00;
        va[1] = 16'hF0F0; vb[1] = 16'h0FF0;
        run_cmd(CMD_AND, 1, 1'b1, -1, 0);
        n_tests++;
        if (timed_out || n_got != 2 || got[0] !== 16'h0000 || got[1] !== 16'h00F0) begin
            n_fail++; $display("FAIL and_res: got n=%0d %h %h expected 2 0000 00f0", n_got, got[0], got[1]);
        end
        n_tests++;
        if (ci_viol != 0) begin
            n_fail++; $display("FAIL and_ci: got %0d issues with alu_ci=1 expected 0", ci_viol);
        end
        n_tests++;
        if (got_flags[3:1] !== 3'b000) begin
            n_fail++; $display("FAIL and_flags_czn: got %b expected 000", got_flags[3:1]);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_cmp();
        test_reset_midop();
        test_stall();
        test_and();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
